// File: rtl/game_pkg.sv
// game_pkg: shared FSM state encoding, default widths and timer sizing for the turn controller
package game_pkg;
  localparam logic [1:0] TURN     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] CHECK    = 2'd2;
  localparam logic [1:0] GAMEOVER = 2'd3;
  localparam int PLAYER_W_DEF = 3;
  localparam int COUNT_W = 8;
  function automatic int timer_w(input int timeout);
    return $clog2(timeout) + 1;
  endfunction
endpackage

// File: rtl/click_edge_detect.sv
// click_edge_detect: two-flop synchroniser on the raw mouse button plus a registered rising-edge pulse
//   clock, reset (sync, active-high), click (async raw level) -> click_rise (1-cycle pulse, 3 clocks after raw edge)
module click_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic click,
  output logic click_rise
);
  logic sync1_q, sync2_q, prev_q, rise_q;
  logic sync1_d, sync2_d, prev_d, rise_d;
  always_comb begin
    sync1_d = click;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
    end
  end
  assign click_rise = rise_q;
endmodule

// File: rtl/game_turn_controller.sv
// game_turn_controller: turn sequencer for N-player grid games driven by mouse clicks
//   in : clock, reset (sync, active-high), click (raw button), move_ack/move_nack (board reply),
//        win_signal (valid the cycle after move_ack), new_game (restart pulse)
//   out: player, move_req (pulse), move_count, game_over, draw, winner, timeout (forfeit pulse)
module game_turn_controller
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int PLAYER_W        = PLAYER_W_DEF,
  parameter int MAX_MOVES       = 9,
  parameter int MOVE_TIMEOUT    = 0,
  parameter int ALTERNATE_START = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                click,
  input  logic                move_ack,
  input  logic                move_nack,
  input  logic                win_signal,
  input  logic                new_game,
  output logic [PLAYER_W-1:0] player,
  output logic                move_req,
  output logic [7:0]          move_count,
  output logic                game_over,
  output logic                draw,
  output logic [PLAYER_W-1:0] winner,
  output logic                timeout
);
  localparam int TW = timer_w(MOVE_TIMEOUT);
  localparam bit TIMEOUT_EN = MOVE_TIMEOUT > 0;
  localparam logic [TW-1:0] LAST_TICK = TW'(MOVE_TIMEOUT - 1);
  localparam logic [PLAYER_W-1:0] LAST_PLAYER = PLAYER_W'(NUM_PLAYERS - 1);
  localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_MOVES);

  logic click_rise;
  logic [1:0] state_q, state_d;
  logic [PLAYER_W-1:0] player_q, player_d, start_q, start_d, winner_q, winner_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic move_req_q, move_req_d, draw_q, draw_d, timeout_q, timeout_d;

  click_edge_detect u_click (
    .clock      (clock),
    .reset      (reset),
    .click      (click),
    .click_rise (click_rise)
  );

  function automatic logic [PLAYER_W-1:0] next_player(input logic [PLAYER_W-1:0] p);
    return (p == LAST_PLAYER) ? '0 : p + 1'b1;
  endfunction

  // The turn timer only runs in TURN; every other path leaves it at zero so each
  // fresh turn starts with a full budget.
  always_comb begin
    state_d    = state_q;
    player_d   = player_q;
    start_d    = start_q;
    count_d    = count_q;
    draw_d     = draw_q;
    winner_d   = winner_q;
    move_req_d = 1'b0;
    timeout_d  = 1'b0;
    timer_d    = '0;
    if (new_game) begin
      state_d  = TURN;
      count_d  = '0;
      draw_d   = 1'b0;
      winner_d = '0;
      start_d  = (ALTERNATE_START != 0) ? next_player(start_q) : '0;
      player_d = start_d;
    end else begin
      case (state_q)
        TURN: begin
          if (click_rise) begin
            move_req_d = 1'b1;
            state_d    = WAIT_ACK;
          end else if (TIMEOUT_EN && timer_q == LAST_TICK) begin
            timeout_d = 1'b1;
            player_d  = next_player(player_q);
          end else if (TIMEOUT_EN) begin
            timer_d = timer_q + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (move_nack) begin
            state_d = TURN;
          end else if (move_ack) begin
            count_d = (count_q == MAX_COUNT) ? count_q : count_q + 1'b1;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (win_signal) begin
            state_d  = GAMEOVER;
            winner_d = player_q;
            draw_d   = 1'b0;
          end else if (count_q == MAX_COUNT) begin
            state_d = GAMEOVER;
            draw_d  = 1'b1;
          end else begin
            player_d = next_player(player_q);
            state_d  = TURN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= TURN;
      player_q   <= '0;
      start_q    <= '0;
      count_q    <= '0;
      draw_q     <= 1'b0;
      winner_q   <= '0;
      move_req_q <= 1'b0;
      timeout_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      player_q   <= player_d;
      start_q    <= start_d;
      count_q    <= count_d;
      draw_q     <= draw_d;
      winner_q   <= winner_d;
      move_req_q <= move_req_d;
      timeout_q  <= timeout_d;
      timer_q    <= timer_d;
    end
  end

  assign player     = player_q;
  assign move_req   = move_req_q;
  assign move_count = count_q;
  assign game_over  = state_q == GAMEOVER;
  assign draw       = draw_q;
  assign winner     = winner_q;
  assign timeout    = timeout_q;
endmodule

// File: tb/tb_game_turn_controller.sv
// tb_game_turn_controller: directed plus randomized checking of two controller configurations against a turn model
module tb_game_turn_controller;
  logic clock, reset, click, move_ack, move_nack, win_signal, new_game;
  logic [2:0] a_player, a_winner, b_player, b_winner;
  logic [7:0] a_count, b_count;
  logic a_req, a_over, a_draw, a_tmo, b_req, b_over, b_draw, b_tmo;
  int checks = 0;
  int failures = 0;
  int a_req_cnt = 0;
  bit started = 0;

  typedef enum int {M_TURN, M_WAIT, M_CHECK, M_OVER} ph_t;
  typedef struct {
    ph_t ph;
    int player, start, count, timer, winner;
    bit req, draw, tmo;
    bit [3:0] h;
  } model_t;
  model_t ma, mb;

  game_turn_controller #(.NUM_PLAYERS(2), .PLAYER_W(3), .MAX_MOVES(9), .MOVE_TIMEOUT(0), .ALTERNATE_START(1)) dut_a (
    .clock(clock), .reset(reset), .click(click), .move_ack(move_ack), .move_nack(move_nack),
    .win_signal(win_signal), .new_game(new_game), .player(a_player), .move_req(a_req),
    .move_count(a_count), .game_over(a_over), .draw(a_draw), .winner(a_winner), .timeout(a_tmo));

  game_turn_controller #(.NUM_PLAYERS(3), .PLAYER_W(3), .MAX_MOVES(4), .MOVE_TIMEOUT(16), .ALTERNATE_START(0)) dut_b (
    .clock(clock), .reset(reset), .click(click), .move_ack(move_ack), .move_nack(move_nack),
    .win_signal(win_signal), .new_game(new_game), .player(b_player), .move_req(b_req),
    .move_count(b_count), .game_over(b_over), .draw(b_draw), .winner(b_winner), .timeout(b_tmo));

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic model_t reset_model();
    model_t n;
    n.ph = M_TURN; n.player = 0; n.start = 0; n.count = 0; n.timer = 0; n.winner = 0;
    n.req = 0; n.draw = 0; n.tmo = 0; n.h = '0;
    return n;
  endfunction

  // Click rise is seen by the turn logic three edges after the raw level is first sampled high.
  function automatic model_t step(input model_t m, input bit rst, input bit c, input bit ack,
                                  input bit nack, input bit w, input bit ng,
                                  input int np, input int maxm, input int to, input bit alt);
    model_t n;
    bit rise;
    if (rst) return reset_model();
    n = m;
    n.req = 0;
    n.tmo = 0;
    rise = m.h[2] & ~m.h[3];
    n.h = {m.h[2:0], c};
    if (ng) begin
      n.ph = M_TURN; n.count = 0; n.draw = 0; n.winner = 0; n.timer = 0;
      n.start = alt ? (m.start + 1) % np : 0;
      n.player = n.start;
    end else if (m.ph == M_TURN) begin
      if (rise) begin
        n.req = 1; n.ph = M_WAIT; n.timer = 0;
      end else if (to > 0 && m.timer == to - 1) begin
        n.tmo = 1; n.player = (m.player + 1) % np; n.timer = 0;
      end else if (to > 0) n.timer = m.timer + 1;
    end else if (m.ph == M_WAIT) begin
      if (nack) n.ph = M_TURN;
      else if (ack) begin n.count = m.count + 1; n.ph = M_CHECK; end
    end else if (m.ph == M_CHECK) begin
      if (w) begin n.ph = M_OVER; n.winner = m.player; n.draw = 0; end
      else if (m.count == maxm) begin n.ph = M_OVER; n.draw = 1; end
      else begin n.player = (m.player + 1) % np; n.ph = M_TURN; end
    end
    return n;
  endfunction

  always @(posedge clock) begin
    ma <= step(ma, reset, click, move_ack, move_nack, win_signal, new_game, 2, 9, 0, 1);
    mb <= step(mb, reset, click, move_ack, move_nack, win_signal, new_game, 3, 4, 16, 0);
    started <= 1'b1;
  end

  always @(negedge clock) begin
    if (a_req) a_req_cnt++;
    if (started) begin
      chk("a_player", a_player, ma.player);
      chk("a_move_req", a_req, ma.req);
      chk("a_move_count", a_count, ma.count);
      chk("a_game_over", a_over, ma.ph == M_OVER);
      chk("a_draw", a_draw, ma.draw);
      chk("a_winner", a_winner, ma.winner);
      chk("a_timeout", a_tmo, ma.tmo);
      chk("b_player", b_player, mb.player);
      chk("b_move_req", b_req, mb.req);
      chk("b_move_count", b_count, mb.count);
      chk("b_game_over", b_over, mb.ph == M_OVER);
      chk("b_draw", b_draw, mb.draw);
      chk("b_winner", b_winner, mb.winner);
      chk("b_timeout", b_tmo, mb.tmo);
    end
  end

  task automatic wait_req();
    bit seen;
    seen = 0;
    click = 1;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clock);
      if (i == 1) click = 0;
      seen = a_req;
    end
    click = 0;
    if (!seen) chk("move_req_wait", 0, 1);
  endtask

  task automatic do_move(input bit w);
    wait_req();
    move_ack = 1;
    @(negedge clock);
    move_ack = 0;
    win_signal = w;
    @(negedge clock);
    win_signal = 0;
  endtask

  task automatic pulse_new_game();
    new_game = 1;
    @(negedge clock);
    new_game = 0;
  endtask

  initial begin
    int base;
    reset = 1; click = 0; move_ack = 0; move_nack = 0; win_signal = 0; new_game = 0;
    repeat (3) @(negedge clock);
    reset = 0;
    chk("reset_player", a_player, 0);
    chk("reset_count", a_count, 0);
    chk("reset_game_over", a_over, 0);
    repeat (15) @(negedge clock);
    chk("b_timeout_before_16", b_tmo, 0);
    @(negedge clock);
    chk("b_timeout_at_16", b_tmo, 1);
    chk("b_player_after_1st_timeout", b_player, 1);
    repeat (16) @(negedge clock);
    chk("b_player_after_2nd_timeout", b_player, 2);
    repeat (16) @(negedge clock);
    chk("b_player_wraps", b_player, 0);
    base = a_req_cnt;
    repeat (3) do_move(0);
    chk("three_moves_player", a_player, 1);
    chk("three_moves_count", a_count, 3);
    chk("three_moves_req_pulses", a_req_cnt - base, 3);
    wait_req();
    move_nack = 1;
    @(negedge clock);
    move_nack = 0;
    @(negedge clock);
    chk("nack_player", a_player, 1);
    chk("nack_count", a_count, 3);
    repeat (6) do_move(0);
    chk("draw_game_over", a_over, 1);
    chk("draw_flag", a_draw, 1);
    chk("draw_count", a_count, 9);
    pulse_new_game();
    chk("new_game_player", a_player, 1);
    chk("new_game_count", a_count, 0);
    chk("new_game_over_cleared", a_over, 0);
    pulse_new_game();
    chk("second_new_game_player", a_player, 0);
    repeat (4) do_move(0);
    do_move(1);
    chk("win_game_over", a_over, 1);
    chk("win_winner", a_winner, 0);
    chk("win_draw", a_draw, 0);
    chk("win_count", a_count, 5);
    base = a_req_cnt;
    click = 1;
    repeat (3) @(negedge clock);
    click = 0;
    repeat (8) @(negedge clock);
    chk("gameover_no_move_req", a_req_cnt - base, 0);
    pulse_new_game();
    wait_req();
    reset = 1;
    move_ack = 1;
    @(negedge clock);
    reset = 0;
    move_ack = 0;
    chk("rst_wait_player", a_player, 0);
    chk("rst_wait_req", a_req, 0);
    chk("rst_wait_count", a_count, 0);
    chk("rst_wait_over", a_over, 0);
    chk("rst_wait_draw", a_draw, 0);
    chk("rst_wait_winner", a_winner, 0);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if ($urandom_range(7) == 0) click = ~click;
      move_ack = $urandom_range(3) == 0;
      move_nack = $urandom_range(9) == 0;
      win_signal = $urandom_range(5) == 0;
      new_game = $urandom_range(149) == 0;
      reset = $urandom_range(699) == 0;
    end
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
